// File: rtl/traffic_pkg.sv
// Shared definitions for the timed highway/country traffic light controller:
// lamp colour codes, state encodings, the lamp-pair struct and the decode
// from state to lamp colours.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    typedef enum logic [2:0] {
        HG    = 3'b000,
        HY    = 3'b001,
        AR1   = 3'b010,
        CG    = 3'b011,
        CY    = 3'b100,
        AR2   = 3'b101,
        FLASH = 3'b110
    } state_t;

    typedef struct packed {
        logic [1:0] hwy;
        logic [1:0] cntry;
    } lamp_t;

    // Lamp colours shown in a given state; blink selects the dark half of the
    // flashing cycle. Any unknown encoding shows all-red.
    function automatic lamp_t lamps_for(state_t s, logic blink);
        lamp_t l;
        l.hwy   = RED;
        l.cntry = RED;
        case (s)
            HG:      begin l.hwy = GREEN;  l.cntry = RED;    end
            HY:      begin l.hwy = YELLOW; l.cntry = RED;    end
            AR1:     begin l.hwy = RED;    l.cntry = RED;    end
            CG:      begin l.hwy = RED;    l.cntry = GREEN;  end
            CY:      begin l.hwy = RED;    l.cntry = YELLOW; end
            AR2:     begin l.hwy = RED;    l.cntry = RED;    end
            FLASH:   begin
                l.hwy   = blink ? OFF : YELLOW;
                l.cntry = blink ? OFF : RED;
            end
            default: begin l.hwy = RED;    l.cntry = RED;    end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase: synchronous clear, tick enable,
// saturates at all-ones, and flags when the count equals a parent-supplied
// target.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             at_target
);

    // Count enabled ticks; clear wins over counting, and the count never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_target = (count == target);

endmodule

// File: rtl/traffic_light_timed.sv
// Highway/country intersection controller. Phases advance only on tick
// pulses, except flash entry/exit and reset. Lamp and walk outputs are
// registered from the next state so they change on the same edge as the
// state register.
module traffic_light_timed
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int T_HWY_MIN   = 20,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 40,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor,
    input  logic       ped_req,
    input  logic       flash,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] HWY_LAST = CNT_W'(T_HWY_MIN - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALLRED - 1);

    state_t           state;
    state_t           next_state;
    logic             req;
    logic             blink;
    logic             next_blink;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] count;
    logic             at_target;
    logic             timer_en;
    logic             timer_clear;
    lamp_t            lamps;

    // The HG timer stops at its minimum so the highway can hold green indefinitely.
    assign timer_en    = tick && !((state == HG) && at_target);
    assign timer_clear = (next_state != state);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .en        (timer_en),
        .target    (target),
        .count     (count),
        .at_target (at_target)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HG;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and timer target for the current phase; flash overrides all.
    always_comb begin
        next_state = state;
        target     = '0;
        case (state)
            HG: begin
                target = HWY_LAST;
                if (tick && at_target && req) next_state = HY;
            end
            HY: begin
                target = YEL_LAST;
                if (tick && at_target) next_state = AR1;
            end
            AR1: begin
                target = AR_LAST;
                if (tick && at_target) next_state = CG;
            end
            CG: begin
                target = MAX_LAST;
                if (tick && (at_target || ((count >= MIN_LAST) && !sensor)))
                    next_state = CY;
            end
            CY: begin
                target = YEL_LAST;
                if (tick && at_target) next_state = AR2;
            end
            AR2: begin
                target = AR_LAST;
                if (tick && at_target) next_state = HG;
            end
            FLASH:   next_state = AR2;
            default: next_state = AR2;
        endcase
        if (flash) next_state = FLASH;
    end

    // Blink phase: starts lit on flash entry and toggles on each tick while flashing.
    assign next_blink = ((state == FLASH) && (next_state == FLASH)) ? (blink ^ tick) : 1'b0;

    // Request latch; clearing on entry to country green beats a same-cycle set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req <= 1'b0;
        end else if ((next_state == CG) && (state != CG)) begin
            req <= 1'b0;
        end else if (sensor || ped_req) begin
            req <= 1'b1;
        end
    end

    // Registered lamp, walk and blink outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink       <= 1'b0;
            lamps.hwy   <= GREEN;
            lamps.cntry <= RED;
            walk        <= 1'b0;
        end else begin
            blink <= next_blink;
            lamps <= lamps_for(next_state, next_blink);
            walk  <= (next_state == CG);
        end
    end

    assign hwy     = lamps.hwy;
    assign cntry   = lamps.cntry;
    assign state_o = state;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Self-checking bench for traffic_light_timed: directed scenarios followed by
// randomized stimulus, all compared against a phase-level reference model.
module tb_traffic_light_timed;

    localparam int HWY_MIN = 4;
    localparam int YEL     = 2;
    localparam int ALLRED  = 1;
    localparam int MIN_G   = 3;
    localparam int MAX_G   = 6;

    // Model phase indices (0..6 equal the published state codes).
    localparam int P_HG = 0, P_HY = 1, P_AR1 = 2, P_CG = 3, P_CY = 4, P_AR2 = 5, P_FL = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, sensor, ped_req, flash;
    logic [1:0] hwy, cntry;
    logic       walk;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    int m_phase, m_ticks, m_req, m_blink;

    traffic_light_timed #(
        .CNT_W(8), .T_HWY_MIN(HWY_MIN), .T_MIN_GREEN(MIN_G),
        .T_MAX_GREEN(MAX_G), .T_YELLOW(YEL), .T_ALLRED(ALLRED)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .sensor(sensor),
        .ped_req(ped_req), .flash(flash), .hwy(hwy), .cntry(cntry),
        .walk(walk), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int phaseLen(int p);
        case (p)
            P_HY, P_CY:   return YEL;
            P_AR1, P_AR2: return ALLRED;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [1:0] expHwy();
        logic [1:0] tab [7] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        if (m_phase == P_FL && m_blink != 0) return 2'b11;
        return tab[m_phase];
    endfunction

    function automatic logic [1:0] expCntry();
        logic [1:0] tab [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
        if (m_phase == P_FL && m_blink != 0) return 2'b11;
        return tab[m_phase];
    endfunction

    task automatic modelReset();
        m_phase = P_HG; m_ticks = 0; m_req = 0; m_blink = 0;
    endtask

    // One clock edge of the reference: the phase ends on the tick that completes it.
    task automatic modelStep(input logic t, input logic s, input logic p, input logic f);
        int nxt;
        int done;
        nxt = m_phase;
        if (f) begin
            if (m_phase != P_FL) begin
                nxt = P_FL; m_blink = 0;
            end else if (t) begin
                m_blink = 1 - m_blink;
            end
        end else if (m_phase == P_FL) begin
            nxt = P_AR2;
        end else if (t) begin
            done = m_ticks + 1;
            case (m_phase)
                P_HG: if (done >= HWY_MIN && m_req != 0) nxt = P_HY;
                P_CG: if ((done >= MIN_G && !s) || done == MAX_G) nxt = P_CY;
                default: if (done == phaseLen(m_phase)) nxt = (m_phase == P_AR2) ? P_HG : m_phase + 1;
            endcase
            m_ticks = done;
        end
        if (nxt == P_CG && m_phase != P_CG) m_req = 0;
        else if (s || p) m_req = 1;
        if (nxt != m_phase) m_ticks = 0;
        m_phase = nxt;
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".state"}, 8'(state_o), 8'(m_phase));
        checkOutput({where, ".hwy"},   8'(hwy),     8'(expHwy()));
        checkOutput({where, ".cntry"}, 8'(cntry),   8'(expCntry()));
        checkOutput({where, ".walk"},  8'(walk),    8'(m_phase == P_CG));
    endtask

    task automatic applyStimulus(input logic t, input logic s, input logic p, input logic f, input string where);
        tick = t; sensor = s; ped_req = p; flash = f;
        @(posedge clk);
        modelStep(t, s, p, f);
        #1;
        checkAll(where);
    endtask

    initial begin
        int walk_cnt;
        int hy_edge;
        int guard;
        logic f;

        reset = 1'b1; tick = 0; sensor = 0; ped_req = 0; flash = 0;
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        #9 reset = 1'b1;

        // Sensor held high: HG x4, HY x2, AR1, CG x6, CY x2, AR2, HG.
        walk_cnt = 0; hy_edge = 0;
        for (int i = 1; i <= 22; i++) begin
            applyStimulus(1, 1, 0, 0, "sensor_hi");
            if (walk) walk_cnt++;
            if (hy_edge == 0 && state_o == 3'b001) hy_edge = i;
        end
        checkOutput("sensor_hi.hg_len", 8'(hy_edge), 8'd4);
        checkOutput("sensor_hi.walk_len", 8'(walk_cnt), 8'(MAX_G));

        // Fresh HG, single ped pulse at timer=1 with sensor low.
        reset = 1'b0; #1 modelReset(); checkAll("reset2"); reset = 1'b1;
        applyStimulus(1, 0, 0, 0, "ped");
        applyStimulus(1, 0, 1, 0, "ped");
        walk_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0, "ped");
            if (walk) walk_cnt++;
        end
        checkOutput("ped.walk_len", 8'(walk_cnt), 8'(MIN_G));

        // Slow ticks, no requests: HG holds; a sensor pulse between ticks is honoured.
        reset = 1'b0; #1 modelReset(); reset = 1'b1;
        for (int i = 0; i < 250; i++) applyStimulus((i % 5) == 4, 0, 0, 0, "idle");
        checkOutput("idle.hwy", 8'(hwy), 8'(2'b10));
        checkOutput("idle.cntry", 8'(cntry), 8'(2'b00));
        applyStimulus(0, 1, 0, 0, "idle_pulse");
        for (int i = 0; i < 12; i++) applyStimulus((i % 5) == 4, 0, 0, 0, "idle_pulse");
        checkOutput("idle_pulse.hy", 8'(state_o), 8'(3'b001));

        // Flash entered from CG at timer=1, then released.
        guard = 0;
        while (m_phase != P_CG && guard < 100) begin
            applyStimulus(1, 1, 0, 0, "to_cg");
            guard++;
        end
        checkOutput("to_cg.bound", 8'(guard < 100), 8'd1);
        applyStimulus(1, 1, 0, 0, "cg");
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1, "flash");
        applyStimulus(1, 0, 0, 0, "unflash");
        checkOutput("unflash.ar2", 8'(state_o), 8'(3'b101));
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "unflash");

        // Reset mid-HY, then the full HG minimum must be served again.
        guard = 0;
        while (m_phase != P_HY && guard < 100) begin
            applyStimulus(1, 1, 0, 0, "to_hy");
            guard++;
        end
        checkOutput("to_hy.bound", 8'(guard < 100), 8'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_rst.state", 8'(state_o), 8'd0);
        checkOutput("async_rst.lamps", 8'({hwy, cntry}), 8'(4'b1000));
        modelReset();
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, "post_rst");

        // Randomized traffic with occasional flash bursts.
        f = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) f = ~f;
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, f, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
